// File: rtl/cam_pkg.sv
// Shared definitions for the synthetic camera transmitter.
//   pattern_e : test pattern codes selected by pattern_sel
//   state_e   : frame sequencing states
//   bar_color : RGB565 colour of each of the eight colour bars
package cam_pkg;

   typedef enum logic [1:0] {
      PAT_SOLID = 2'd0,
      PAT_BARS  = 2'd1,
      PAT_GRAD  = 2'd2,
      PAT_CHECK = 2'd3
   } pattern_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_VSYNC  = 3'd1,
      ST_VBACK  = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_VFRONT = 3'd4
   } state_e;

   localparam int unsigned BAR_COUNT = 8;

   // White, yellow, cyan, green, magenta, red, blue, black
   function automatic logic [15:0] bar_color(input logic [2:0] idx);
      logic [15:0] c;
      case (idx)
         3'd0:    c = 16'hFFFF;
         3'd1:    c = 16'hFFE0;
         3'd2:    c = 16'h07FF;
         3'd3:    c = 16'h07E0;
         3'd4:    c = 16'hF81F;
         3'd5:    c = 16'hF800;
         3'd6:    c = 16'h001F;
         default: c = 16'h0000;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cam_pattern_pixel.sv
// Combinational test-pattern generator: pixel position and pattern -> RGB565.
//   x_hi        : pixel column bits [5:1]
//   y           : active line bits [5:0]
//   bar_idx     : colour bar index maintained by the caller's bar counter
//   pattern     : selected pattern
//   solid_color : colour for the solid pattern
//   pixel_c     : RGB565 result
module cam_pattern_pixel
   import cam_pkg::*;
(
   input  logic [5:1]  x_hi,
   input  logic [5:0]  y,
   input  logic [2:0]  bar_idx,
   input  pattern_e    pattern,
   input  logic [15:0] solid_color,
   output logic [15:0] pixel_c
);

   // Pattern select
   always_comb begin
      pixel_c = 16'h0000;
      case (pattern)
         PAT_SOLID: pixel_c = solid_color;
         PAT_BARS:  pixel_c = bar_color(bar_idx);
         PAT_GRAD:  pixel_c = {x_hi, y, 5'b00000};
         PAT_CHECK: pixel_c = (x_hi[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
         default:   pixel_c = 16'h0000;
      endcase
   end

endmodule

// File: rtl/cam_stream_gen.sv
// Synthetic OV7670-style camera transmitter: VSYNC/HREF framing plus a
// byte-serial RGB565 stream (high byte first) from an internal test pattern.
//   CLK, RST_N  : byte clock, asynchronous active-low reset
//   enable      : permit frames to start (sampled only between frames)
//   pattern_sel : 0 solid, 1 colour bars, 2 gradient, 3 checkerboard
//   solid_color : RGB565 colour for the solid pattern
//   VSYNC       : frame sync, active high
//   HREF        : high during the active bytes of a line
//   data_out    : pixel byte, zero whenever HREF is low
//   frame_done  : one-cycle pulse on the last cycle of a frame
module cam_stream_gen
   import cam_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = 176,
   parameter int unsigned V_ACTIVE    = 144,
   parameter int unsigned H_BLANK     = 16,
   parameter int unsigned VSYNC_LINES = 3,
   parameter int unsigned V_BACK      = 10,
   parameter int unsigned V_FRONT     = 4
)(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   input  logic [15:0] solid_color,
   output logic        VSYNC,
   output logic        HREF,
   output logic [7:0]  data_out,
   output logic        frame_done
);

   localparam int unsigned LINE    = 2 * H_ACTIVE + H_BLANK;
   localparam int unsigned ACT_B   = 2 * H_ACTIVE;
   localparam int unsigned C_W     = $clog2(LINE);
   localparam int unsigned MAX_A   = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
   localparam int unsigned MAX_B   = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
   localparam int unsigned MAX_L   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned L_W     = $clog2(MAX_L + 1);
   localparam int unsigned BAR_W   = H_ACTIVE / BAR_COUNT;
   localparam int unsigned BW_W    = $clog2(BAR_W + 1);

   state_e            state_q, state_n;
   logic [C_W-1:0]    col_q, col_n;
   logic [L_W-1:0]    line_q, line_n;
   logic [BW_W-1:0]   bar_px_q, bar_px_n;
   logic [2:0]        bar_idx_q, bar_idx_n;
   pattern_e          pat_q, pat_n;
   logic [15:0]       color_q, color_n;

   logic              col_last_c;
   logic              line_last_c;
   logic              frame_end_c;
   logic              vsync_n, href_n, done_n;
   logic [7:0]        data_n;
   logic [15:0]       pixel_c;

   function automatic int unsigned lines_of(input state_e st);
      int unsigned n;
      case (st)
         ST_VSYNC:  n = VSYNC_LINES;
         ST_VBACK:  n = V_BACK;
         ST_ACTIVE: n = V_ACTIVE;
         ST_VFRONT: n = V_FRONT;
         default:   n = 1;
      endcase
      return n;
   endfunction

   // True on the final cycle of a frame (last column of the last non-empty state)
   function automatic logic is_frame_end(input state_e st, input logic [C_W-1:0] col,
                                         input logic [L_W-1:0] ln);
      return (col == C_W'(LINE - 1)) && (ln == L_W'(lines_of(st) - 1)) &&
             ((st == ST_VFRONT) || ((st == ST_ACTIVE) && (V_FRONT == 0)));
   endfunction

   // State, counter and output registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= ST_IDLE;
         col_q      <= '0;
         line_q     <= '0;
         bar_px_q   <= '0;
         bar_idx_q  <= '0;
         pat_q      <= PAT_SOLID;
         color_q    <= 16'h0000;
         VSYNC      <= 1'b0;
         HREF       <= 1'b0;
         data_out   <= 8'h00;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_n;
         col_q      <= col_n;
         line_q     <= line_n;
         bar_px_q   <= bar_px_n;
         bar_idx_q  <= bar_idx_n;
         pat_q      <= pat_n;
         color_q    <= color_n;
         VSYNC      <= vsync_n;
         HREF       <= href_n;
         data_out   <= data_n;
         frame_done <= done_n;
      end
   end

   // Next-state and counter sequencing
   always_comb begin
      state_n     = state_q;
      col_n       = col_q;
      line_n      = line_q;
      pat_n       = pat_q;
      color_n     = color_q;
      col_last_c  = (col_q == C_W'(LINE - 1));
      line_last_c = (line_q == L_W'(lines_of(state_q) - 1));
      frame_end_c = is_frame_end(state_q, col_q, line_q);

      if (state_q == ST_IDLE || frame_end_c) begin
         if (enable) begin
            state_n = ST_VSYNC;
            col_n   = '0;
            line_n  = '0;
            pat_n   = pattern_e'(pattern_sel);
            color_n = solid_color;
         end else begin
            state_n = ST_IDLE;
            col_n   = '0;
            line_n  = '0;
         end
      end else begin
         col_n = col_last_c ? '0 : col_q + C_W'(1);
         if (col_last_c) begin
            if (line_last_c) begin
               line_n = '0;
               case (state_q)
                  ST_VSYNC:  state_n = (V_BACK != 0) ? ST_VBACK : ST_ACTIVE;
                  ST_VBACK:  state_n = ST_ACTIVE;
                  ST_ACTIVE: state_n = ST_VFRONT;
                  default:   state_n = ST_IDLE;
               endcase
            end else begin
               line_n = line_q + L_W'(1);
            end
         end
      end
   end

   // Bar counter tracks col_n: advances once per pixel, no divide by BAR_W
   always_comb begin
      bar_px_n  = bar_px_q;
      bar_idx_n = bar_idx_q;
      if (col_n == '0) begin
         bar_px_n  = '0;
         bar_idx_n = '0;
      end else if (!col_n[0] && (col_n < C_W'(ACT_B))) begin
         if (bar_px_q == BW_W'(BAR_W - 1)) begin
            bar_px_n  = '0;
            bar_idx_n = bar_idx_q + 3'd1;
         end else begin
            bar_px_n = bar_px_q + BW_W'(1);
         end
      end
   end

   cam_pattern_pixel u_pixel (
      .x_hi        (5'(col_n >> 2)),
      .y           (6'(line_n)),
      .bar_idx     (bar_idx_n),
      .pattern     (pat_n),
      .solid_color (color_n),
      .pixel_c     (pixel_c)
   );

   // Outputs are decoded from the next-state values so they align with the registers
   always_comb begin
      vsync_n = (state_n == ST_VSYNC);
      href_n  = (state_n == ST_ACTIVE) && (col_n < C_W'(ACT_B));
      data_n  = 8'h00;
      if (href_n) begin
         data_n = col_n[0] ? pixel_c[7:0] : pixel_c[15:8];
      end
      done_n  = is_frame_end(state_n, col_n, line_n);
   end

endmodule
